// File: rtl/rijndael_pkg.sv
// ============================================================================
// Module  : rijndael_pkg
// Purpose : Shared types, constants and helpers for the Rijndael key schedule.
//           - word_t   : 32-bit key-schedule word
//           - state_t  : key-expansion FSM states
//           - RCON_INIT: first round constant
//           - xtime    : GF(2^8) multiply-by-x
//           - nr_for_nk: number of rounds for a given key length
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rijndael_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEY    = 2'd1,
    EXPAND = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rijndael_sbox.sv
// ============================================================================
// Module  : rijndael_sbox
// Purpose : Forward Rijndael byte substitution (combinational lookup).
// Ports   : i_byte - input byte
//           o_byte - substituted byte
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rijndael_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the most significant byte of the table.
  localparam logic [2047:0] c_table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset (255 - x) * 8, and (255 - x) == ~x.
  assign o_byte = c_table[{~i_byte, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/rijndael_sub_word.sv
// ============================================================================
// Module  : rijndael_sub_word
// Purpose : SubWord - applies the Rijndael S-box to each byte of a word.
// Ports   : i_word - input word
//           o_word - byte-wise substituted word
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rijndael_sub_word
  import rijndael_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_byte
      rijndael_sbox u_sbox (
        .i_byte (i_word[8*g +: 8]),
        .o_byte (o_word[8*g +: 8])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rijndael_key_expansion.sv
// ============================================================================
// Module  : rijndael_key_expansion
// Purpose : Iterative AES key schedule; streams w[0..NW-1] one word per cycle
//           over a valid/ready interface. NK (4/6/8) selects the key size.
// Ports   : clk_i        - clock
//           rst_i        - asynchronous active-high reset
//           start_i      - start request, sampled only while idle
//           key_i        - cipher key, w[0] in the top 32 bits
//           busy_o       - expansion in progress
//           word_o       - current expanded-key word
//           word_idx_o   - index of word_o
//           word_valid_o - word_o / word_idx_o valid
//           word_ready_i - downstream accepts the word
//           word_last_o  - word_o is w[NW-1]
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rijndael_key_expansion
  import rijndael_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [32*NK-1:0] key_i,
  output logic            busy_o,
  output logic [31:0]     word_o,
  output logic [5:0]      word_idx_o,
  output logic            word_valid_o,
  input  logic            word_ready_i,
  output logic            word_last_o
);

  localparam int         c_nr       = nr_for_nk(NK);
  localparam int         c_nw       = 4 * (c_nr + 1);
  localparam int         c_sel_w    = $clog2(NK);
  localparam logic [5:0] c_last_idx = 6'(c_nw - 1);
  localparam logic [5:0] c_key_last = 6'(NK - 1);
  localparam logic [2:0] c_ph_max   = 3'(NK - 1);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("rijndael_key_expansion: NK must be 4, 6 or 8");
    end
  endgenerate

  state_t     r_state;
  word_t      r_win [NK];   // w[i-NK .. i-1] for the next word to compute
  logic [7:0] r_rcon;
  logic [2:0] r_phase;      // (index of next computed word) mod NK
  word_t      r_word;
  logic [5:0] r_idx;
  logic       r_valid;
  logic       r_last;
  logic       r_busy;

  logic       w_hs;
  logic       w_compute;
  logic       w_rcon_adv;
  logic [5:0] w_next_idx;
  word_t      w_temp;
  word_t      w_sub_in;
  word_t      w_sub_out;
  word_t      w_mix;
  word_t      w_new;

  assign w_hs       = r_valid && word_ready_i;
  assign w_next_idx = r_idx + 6'd1;

  // A new word is computed on every handshake from idx NK-1 up to NW-2, so
  // the first expanded word follows the last key word without a bubble.
  assign w_compute = w_hs &&
                     (((r_state == KEY) && (r_idx == c_key_last)) ||
                      ((r_state == EXPAND) && !r_last));

  // Only step rcon if a later word still needs the next constant.
  assign w_rcon_adv = (r_phase == 3'd0) && ((int'(w_next_idx) + NK) < c_nw);

  always_comb begin
    w_temp   = r_win[NK-1];
    w_sub_in = (r_phase == 3'd0) ? {w_temp[23:0], w_temp[31:24]} : w_temp;
  end

  rijndael_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_mix = w_temp;
    if (r_phase == 3'd0) begin
      w_mix = w_sub_out ^ {r_rcon, 24'h000000};
    end else if ((NK == 8) && (r_phase == 3'd4)) begin
      w_mix = w_sub_out;
    end
    w_new = r_win[0] ^ w_mix;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rcon  <= RCON_INIT;
      r_phase <= 3'd0;
      r_word  <= '0;
      r_idx   <= 6'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            for (int j = 0; j < NK; j++) r_win[j] <= key_i[32*(NK-j)-1 -: 32];
            r_word  <= key_i[32*NK-1 -: 32];
            r_idx   <= 6'd0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_rcon  <= RCON_INIT;
            r_phase <= 3'd0;
            r_state <= KEY;
          end
        end
        KEY: begin
          if (w_hs) begin
            r_idx <= w_next_idx;
            if (r_idx == c_key_last) begin
              r_word  <= w_new;
              r_state <= EXPAND;
            end else begin
              r_word <= r_win[w_next_idx[c_sel_w-1:0]];
            end
          end
        end
        EXPAND: begin
          if (w_hs) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_word <= w_new;
              r_idx  <= w_next_idx;
              r_last <= (w_next_idx == c_last_idx);
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Window slide, phase and rcon advance only when a word is produced.
      if (w_compute) begin
        for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
        r_win[NK-1] <= w_new;
        r_phase     <= (r_phase == c_ph_max) ? 3'd0 : r_phase + 3'd1;
        if (w_rcon_adv) r_rcon <= xtime(r_rcon);
      end
    end
  end

  assign busy_o       = r_busy;
  assign word_o       = r_word;
  assign word_idx_o   = r_idx;
  assign word_valid_o = r_valid;
  assign word_last_o  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_rijndael_key_expansion.sv
// ============================================================================
// Module  : tb_rijndael_key_expansion
// Purpose : Self-checking bench for rijndael_key_expansion (NK = 4, 6, 8).
//           Expected words come from an independent behavioural key schedule
//           whose S-box is derived from GF(2^8) inversion plus the affine map.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rijndael_key_expansion;

  localparam logic [127:0] c_k4a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_k4b = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] c_k6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] c_k8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk;
  logic         rst;

  logic         start4, busy4, valid4, ready4, last4;
  logic [127:0] key4;
  logic [31:0]  word4;
  logic [5:0]   idx4;

  logic         start6, busy6, valid6, last6;
  logic [191:0] key6;
  logic [31:0]  word6;
  logic [5:0]   idx6;

  logic         start8, busy8, valid8, last8;
  logic [255:0] key8;
  logic [31:0]  word8;
  logic [5:0]   idx8;

  logic         ready_wide;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           hs_cnt4 = 0;
  bit           rnd_en  = 1'b0;

  logic [7:0]   sb [256];
  logic [31:0]  exp_w [60];
  logic [31:0]  cap4 [64];
  logic [31:0]  capw [64];
  logic [37:0]  q4 [$];
  logic [37:0]  qw [$];

  logic         prev_stall4 = 1'b0;
  logic [31:0]  prev_word4;
  logic [5:0]   prev_idx4;
  logic         prev_last4;

  rijndael_key_expansion #(.NK(4)) u_dut4 (
    .clk_i (clk), .rst_i (rst), .start_i (start4), .key_i (key4),
    .busy_o (busy4), .word_o (word4), .word_idx_o (idx4),
    .word_valid_o (valid4), .word_ready_i (ready4), .word_last_o (last4)
  );

  rijndael_key_expansion #(.NK(6)) u_dut6 (
    .clk_i (clk), .rst_i (rst), .start_i (start6), .key_i (key6),
    .busy_o (busy6), .word_o (word6), .word_idx_o (idx6),
    .word_valid_o (valid6), .word_ready_i (ready_wide), .word_last_o (last6)
  );

  rijndael_key_expansion #(.NK(8)) u_dut8 (
    .clk_i (clk), .rst_i (rst), .start_i (start8), .key_i (key8),
    .busy_o (busy8), .word_o (word8), .word_idx_o (idx8),
    .word_valid_o (valid8), .word_ready_i (ready_wide), .word_last_o (last8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits: w[0] in bits 255:224.
  task automatic expand_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) exp_w[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  // ---------------- NK=4 ready driver and scoreboard monitor ----------------
  initial begin
    ready4 = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready4 = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [37:0] e;
    if (rst) begin
      prev_stall4 = 1'b0;
    end else begin
      if (prev_stall4) begin
        check("hold_word", word4, prev_word4);
        check("hold_idx", 32'(idx4), 32'(prev_idx4));
        check("hold_last", 32'(last4), 32'(prev_last4));
      end
      if (valid4 && ready4) begin
        if (q4.size() == 0) begin
          check("sb4_empty", 32'(q4.size()), 32'd1);
        end else begin
          e = q4.pop_front();
          check("w4_word", word4, e[31:0]);
          check("w4_idx", 32'(idx4), 32'(e[37:32]));
          check("w4_last", 32'(last4), 32'(e[37:32] == 6'd43));
        end
        cap4[idx4] = word4;
        hs_cnt4++;
      end
      prev_stall4 = valid4 && !ready4;
      prev_word4  = word4;
      prev_idx4   = idx4;
      prev_last4  = last4;
    end
  end

  task automatic start4_run(input logic [127:0] k);
    expand_model({k, 128'h0}, 4);
    for (int i = 0; i < 44; i++) q4.push_back({6'(i), exp_w[i]});
    hs_cnt4 = 0;
    @(posedge clk); #1;
    key4   = k;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    key4   = 128'($urandom) << 64;
    check("lat_valid", 32'(valid4), 32'd1);
    check("lat_busy", 32'(busy4), 32'd1);
    check("lat_idx", 32'(idx4), 32'd0);
  endtask

  task automatic wait_done4(input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (valid4 && ready4 && last4) done = 1'b1;
    end
    if (!done) check("done4_timeout", 32'(last4), 32'd1);
    @(posedge clk); #1;
    check("end_busy", 32'(busy4), 32'd0);
    check("end_valid", 32'(valid4), 32'd0);
    check("hs_count", 32'(hs_cnt4), 32'd44);
  endtask

  task automatic wait_idx4(input logic [5:0] target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < budget && !hit; t++) begin
      @(negedge clk);
      if (valid4 && idx4 == target) hit = 1'b1;
    end
    if (!hit) check("idx4_timeout", 32'(idx4), 32'(target));
  endtask

  // ---------------- NK=6 / NK=8 full-rate runs ----------------
  task automatic run_wide(input bit is8, input logic [255:0] k);
    int          nk, nw;
    logic [37:0] e;
    logic        v, l;
    logic [31:0] w;
    logic [5:0]  ix;
    nk = is8 ? 8 : 6;
    nw = 4 * (nk + 7);
    expand_model(k, nk);
    for (int i = 0; i < nw; i++) qw.push_back({6'(i), exp_w[i]});
    @(posedge clk); #1;
    if (is8) begin key8 = k; start8 = 1'b1; end
    else     begin key6 = k[255:64]; start6 = 1'b1; end
    @(posedge clk); #1;
    start6 = 1'b0;
    start8 = 1'b0;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      v  = is8 ? valid8 : valid6;
      l  = is8 ? last8  : last6;
      w  = is8 ? word8  : word6;
      ix = is8 ? idx8   : idx6;
      check("wide_valid", 32'(v), 32'd1);
      e = qw.pop_front();
      check("wide_word", w, e[31:0]);
      check("wide_idx", 32'(ix), 32'(e[37:32]));
      check("wide_last", 32'(l), 32'(i == nw - 1));
      capw[ix] = w;
    end
    @(posedge clk); #1;
    check("wide_end_busy", 32'(is8 ? busy8 : busy6), 32'd0);
    check("wide_end_valid", 32'(is8 ? valid8 : valid6), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_sbox();
    rst = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    ready_wide = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_valid", 32'(valid4), 32'd0);
    check("rst_last", 32'(last4), 32'd0);
    check("rst_word", word4, 32'd0);
    check("rst_idx", 32'(idx4), 32'd0);
    rst = 1'b0;

    // NK=4 full rate
    start4_run(c_k4a);
    wait_done4(100);
    check("k4_w0", cap4[0], 32'h2b7e1516);
    check("k4_w4", cap4[4], 32'ha0fafe17);
    check("k4_w43", cap4[43], 32'hb6630ca6);

    // NK=6 and NK=8
    run_wide(1'b0, {c_k6, 64'h0});
    check("k6_w6", capw[6], 32'hfe0c91f7);
    check("k6_w51", capw[51], 32'h01002202);
    run_wide(1'b1, c_k8);
    check("k8_w8", capw[8], 32'h9ba35411);
    check("k8_w12", capw[12], 32'ha8b09c1a);
    check("k8_w59", capw[59], 32'h706c631e);

    // NK=4 with random backpressure
    rnd_en = 1'b1;
    start4_run(c_k4a);
    wait_done4(2000);
    rnd_en = 1'b0;
    check("rnd_w43", cap4[43], 32'hb6630ca6);

    // start while busy is ignored, then a fresh start picks up the new key
    start4_run(c_k4a);
    wait_idx4(6'd10, 100);
    @(posedge clk); #1;
    key4   = c_k4b;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done4(100);
    check("busy_start_w43", cap4[43], 32'hb6630ca6);
    start4_run(c_k4b);
    wait_done4(100);
    check("newkey_w0", cap4[0], 32'h00010203);

    // asynchronous reset mid-stream
    start4_run(c_k4a);
    wait_idx4(6'd20, 100);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid4), 32'd0);
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_word", word4, 32'd0);
    check("arst_idx", 32'(idx4), 32'd0);
    check("arst_last", 32'(last4), 32'd0);
    q4.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(valid4), 32'd0);
    end
    start4_run(c_k4a);
    wait_done4(100);
    check("rerun_w4", cap4[4], 32'ha0fafe17);
    check("sb4_drained", 32'(q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rijndael_key_expansion.md
Name: rijndael_key_expansion

Overview:
Iterative Rijndael/AES key schedule. Accepts a cipher key, then streams the expanded key words w[0..4*(NR+1)-1] one 32-bit word per cycle over a valid/ready interface. It sits directly upstream of the round datapath and is the main consumer of the byte S-box, through four instances used for SubWord. It supports 128-, 192- and 256-bit keys, selected at elaboration.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
NR, NK+6, number of rounds; derived, must not be overridden.
NW, 4*(NR+1), total words emitted: 44, 52 or 60.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous active-high reset.
start_i  in  1  start request; sampled only while idle.
key_i  in  32*NK  cipher key; key_i[32*NK-1 -: 32] is w[0] (FIPS-197 byte order, byte 0 in the MSBs).
busy_o  out  1  high from the cycle after start is accepted until the last word handshakes.
word_o  out  32  current expanded-key word.
word_idx_o  out  6  index i of word_o.
word_valid_o  out  1  word_o / word_idx_o are valid.
word_ready_i  in  1  downstream accepts the word; a handshake occurs when word_valid_o && word_ready_i.
word_last_o  out  1  high with the word whose index is NW-1.

Behaviour:
- Reset (asynchronous, active-high): busy_o=0, word_valid_o=0, word_last_o=0, word_o=0, word_idx_o=0, FSM=IDLE, rcon=8'h01, window cleared. A reset asserted mid-expansion aborts it immediately. No partial output resumes after reset release.
- FSM has three states: IDLE, KEY, EXPAND.
- IDLE: start_i=1 captures key_i into the NK-word window, sets rcon=01 and moves to KEY. The first word (w[0], idx 0) is valid in the next cycle, so latency is 1 cycle.
- KEY: presents w[0]..w[NK-1] straight from the captured key. On the handshake of idx NK-1, moves to EXPAND.
- EXPAND: for i = NK..NW-1, with temp = w[i-1]:
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}; then rcon = xtime(rcon), meaning shift left and XOR 8'h1b if the MSB was set.
  - If NK==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - The handshake of idx NW-1 returns the FSM to IDLE, with busy_o=0 and word_valid_o=0 in the next cycle.
- Throughput: one word per cycle while word_ready_i=1. There are no bubbles between the KEY and EXPAND phases.
- Backpressure: while word_valid_o && !word_ready_i, word_o, word_idx_o and word_last_o hold stable, and rcon and the window do not advance.
- start_i while busy is ignored; the key is not re-captured. start_i in the same cycle as the final handshake is also ignored.
- key_i is sampled only in the start cycle; later changes to it have no effect.
- Index arithmetic: mod-NK detection uses a separate phase counter that wraps at NK-1, not division.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. It is never advanced beyond the value needed for the last word.
- word_ready_i while word_valid_o=0 has no effect.

Decomposition:
- Shared package rijndael_pkg holds:
  - the xtime function;
  - the RCON_INIT constant (8'h01);
  - the nr_for_nk function;
  - a state enum typedef (IDLE, KEY, EXPAND);
  - the word_t typedef (logic [31:0]).
- One natural sub-module, rijndael_sub_word: four rijndael_sbox instances applied bytewise to a 32-bit word, purely combinational.
- RotWord and the XORs stay inline.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, ready held high:
  - 44 consecutive words;
  - w[4]=a0fafe17, w[43]=b6630ca6;
  - word_last_o only with idx 43;
  - busy_o falls the cycle after.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: w[6]=fe0c91f7, w[51]=01002202, 52 words total.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8]=9ba35411, w[12]=a8b09c1a (checks the i mod 8 == 4 SubWord path);
  - w[59]=706c631e.
- Random word_ready_i (about 50%) with the NK=4 vector: the word sequence is identical to the full-rate run; outputs are stable during every stall; no word is duplicated or dropped.
- start_i pulsed at idx 10 with a different key_i: the stream continues on the original key; after completion, a new start emits the new key's w[0] one cycle later.
- rst_i asserted asynchronously at idx 20:
  - outputs go to reset values immediately;
  - word_valid_o stays 0 after release until the next start;
  - a fresh start reproduces w[0..43] exactly.
